// File: rtl/bus_pkg.sv
// Shared definitions for the narrow/wide bus width converters.
package bus_pkg;

  // Packer FSM encoding.
  typedef enum logic {
    COLLECT = 1'b0,
    WAIT    = 1'b1
  } state_e;

  // Default geometry and the derived helper constants for it.
  localparam int DEF_LOW_DATA_WIDTH = 32;
  localparam int DEF_BRUST_SIZE_LOG = 2;
  localparam int BEATS              = 2 ** DEF_BRUST_SIZE_LOG;
  localparam int HIGH_DATA_WIDTH    = DEF_LOW_DATA_WIDTH * BEATS;

  // Beats per wide word for an arbitrary burst size.
  function automatic int calc_beats(input int brust_size_log);
    return 2 ** brust_size_log;
  endfunction

  // Wide word width for an arbitrary geometry.
  function automatic int calc_high_width(input int low_width, input int brust_size_log);
    return low_width * (2 ** brust_size_log);
  endfunction

  // Observable FSM state; beat_cnt is zero-extended to 8 bits.
  typedef struct packed {
    state_e     state;
    logic [7:0] beat_cnt;
  } dbg_t;

endpackage

// File: rtl/low_to_high.sv
// Narrow-to-wide bus packer: gathers 2**BRUST_SIZE_LOG narrow beats into one
// wide word, first beat in the LSBs.
//
// Handshake (both sides): *_valid is a one-cycle pulse announcing data; the
// consumer answers with a one-cycle *_finish pulse once the data is taken.
// The producer must not send again until the cycle after finish. The last
// narrow beat of a word is only finished once the wide word itself has been
// finished downstream, which is how back-pressure propagates upstream.
module low_to_high
  import bus_pkg::*;
#(
  parameter int LOW_DATA_WIDTH = 32,
  parameter int BRUST_SIZE_LOG = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [LOW_DATA_WIDTH-1:0]                     low_read_data,
  input  logic                                          low_read_valid,
  output logic                                          low_read_finish,
  output logic [LOW_DATA_WIDTH*(2**BRUST_SIZE_LOG)-1:0] high_write_data,
  output logic                                          high_write_valid,
  input  logic                                          high_write_finish,
  output dbg_t                                          dbg
);

  localparam int N_BEATS = calc_beats(BRUST_SIZE_LOG);
  localparam int W_HIGH  = calc_high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG);

  state_e                    state_q, state_d;
  logic [BRUST_SIZE_LOG-1:0] beat_cnt_q, beat_cnt_d;
  logic [W_HIGH-1:0]         pack_buf_q, pack_buf_d;
  logic [W_HIGH-1:0]         data_q, data_d;
  logic                      finish_q, finish_d;
  logic                      valid_q, valid_d;
  logic [W_HIGH-1:0]         merged;

  // Registered state, buffers and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      beat_cnt_q <= '0;
      pack_buf_q <= '0;
      data_q     <= '0;
      finish_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pack_buf_q <= pack_buf_d;
      data_q     <= data_d;
      finish_q   <= finish_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic; the incoming beat is merged into the buffer image so the
  // last beat lands in the wide word directly rather than via the stale slice.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pack_buf_d = pack_buf_q;
    data_d     = data_q;
    finish_d   = 1'b0;
    valid_d    = 1'b0;
    merged     = pack_buf_q;
    merged[int'(beat_cnt_q)*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] = low_read_data;

    unique case (state_q)
      COLLECT: begin
        if (low_read_valid) begin
          pack_buf_d = merged;
          if (&beat_cnt_q) begin
            data_d     = merged;
            valid_d    = 1'b1;
            beat_cnt_d = '0;
            state_d    = WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            finish_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (high_write_finish) begin
          finish_d = 1'b1;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign low_read_finish  = finish_q;
  assign high_write_valid = valid_q;
  assign high_write_data  = data_q;
  assign dbg.state        = state_q;
  assign dbg.beat_cnt     = 8'(beat_cnt_q);

endmodule
